// File: rtl/clahe_gray_feeder.sv
// clahe_gray_feeder: RGB-to-luma feeder with frame counting, last/pass tagging; CLAHE_GRAY_ROUND_EN selects rounded luma
module clahe_gray_feeder #(
  parameter int WIDTH = 1920,
  parameter int HEIGHT = 1080,
  localparam int PIX_W = $clog2(WIDTH*HEIGHT)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [23:0] in_rgb,
  input  logic        in_sof,
  output logic        y_valid,
  output logic [7:0]  y_data,
  output logic        y_last,
  output logic        pass,
  output logic        frame_err
);
  localparam int N = WIDTH*HEIGHT;
  typedef enum logic {WAIT_SOF, IN_FRAME} state_t;
  state_t state;
  logic [PIX_W-1:0] count, idx;
  logic pass_r, early, accept, last_hit, tag_pass;
  logic [15:0] p_r, p_g, p_b;
  logic [16:0] sum;
  logic v1, l1, pa1, v2, l2, pa2;
  always_comb begin
    early = in_valid & in_sof & (state == IN_FRAME) & (count != '0);
    accept = in_valid & (in_sof | (state == IN_FRAME));
    idx = in_sof ? '0 : count;
    last_hit = accept & (idx == PIX_W'(N-1));
    tag_pass = early ? 1'b0 : pass_r;
  end
  // an early sof restarts the frame at count 0 and resynchronises pass to the statistics copy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= WAIT_SOF;
      count <= '0;
      pass_r <= 1'b0;
    end else if (accept) begin
      state <= last_hit ? WAIT_SOF : IN_FRAME;
      count <= last_hit ? '0 : idx + PIX_W'(1);
      pass_r <= last_hit ? ~tag_pass : tag_pass;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {v1, l1, pa1, v2, l2, pa2, frame_err} <= '0;
      {p_r, p_g, p_b} <= '0;
      sum <= '0;
      {y_valid, y_last, pass} <= '0;
      y_data <= '0;
    end else begin
      v1 <= accept;
      l1 <= last_hit;
      frame_err <= early;
      if (accept) begin
        p_r <= 16'(in_rgb[23:16]) * 16'd77;
        p_g <= 16'(in_rgb[15:8]) * 16'd150;
        p_b <= 16'(in_rgb[7:0]) * 16'd29;
        pa1 <= tag_pass;
      end
      v2 <= v1;
      l2 <= l1;
      if (v1) begin
        sum <= 17'(p_r) + 17'(p_g) + 17'(p_b);
        pa2 <= pa1;
      end
      y_valid <= v2;
      y_last <= l2;
      if (v2) begin
`ifdef CLAHE_GRAY_ROUND_EN
        y_data <= 8'((sum + 17'd128) >> 8);
`else
        y_data <= 8'(sum >> 8);
`endif
        pass <= pa2;
      end
    end
endmodule

// File: tb/tb_clahe_gray_feeder.sv
// tb_clahe_gray_feeder: directed checks of luma, framing, pass, error and reset behaviour
module tb_clahe_gray_feeder;
  localparam int W = 16, H = 8;
`ifdef CLAHE_GRAY_ROUND_EN
  localparam logic [7:0] RED_Y = 8'd77;
`else
  localparam logic [7:0] RED_Y = 8'd76;
`endif
  logic clk = 0, rst_n = 0, in_valid = 0, in_sof = 0;
  logic [23:0] in_rgb = '0;
  logic y_valid, y_last, pass, frame_err;
  logic [7:0] y_data;
  logic e_acc = 0, e_last = 0, e_pass = 0, e_err = 0;
  logic [7:0] e_y = '0;
  logic [2:0] hv, hl, hp;
  logic [7:0] hy0, hy1, hy2;
  logic he;
  int checks = 0, failures = 0, nv = 0, nl = 0, ne = 0;
  int bv, bl, be;
  clahe_gray_feeder #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_rgb(in_rgb), .in_sof(in_sof),
    .y_valid(y_valid), .y_data(y_data), .y_last(y_last), .pass(pass), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask
  // expected tags ride a 3-deep delay line; frame_err expectation a 1-deep one
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hv <= '0; hl <= '0; hp <= '0; he <= 1'b0;
      hy0 <= '0; hy1 <= '0; hy2 <= '0;
    end else begin
      hv <= {hv[1:0], e_acc};
      hl <= {hl[1:0], e_last};
      hp <= {hp[1:0], e_pass};
      hy2 <= hy1; hy1 <= hy0; hy0 <= e_y;
      he <= e_err;
    end
  always @(negedge clk)
    if (rst_n) begin
      chk("y_valid", y_valid, hv[2]);
      chk("frame_err", frame_err, he);
      if (hv[2]) begin
        chk("y_data", y_data, hy2);
        chk("y_last", y_last, hl[2]);
        chk("pass", pass, hp[2]);
      end else chk("y_last_idle", y_last, 0);
      nv += y_valid;
      nl += y_last;
      ne += frame_err;
    end
  task automatic px(input logic v, input logic [23:0] rgb, input logic sof, input logic acc,
                    input logic lst, input logic ps, input logic er, input logic [7:0] y);
    in_valid = v; in_rgb = rgb; in_sof = sof;
    e_acc = acc; e_last = lst; e_pass = ps; e_err = er; e_y = y;
    @(posedge clk); #1;
  endtask
  task automatic idle(input int n);
    repeat (n) px(0, '0, 0, 0, 0, 0, 0, '0);
  endtask
  task automatic gray_frame(input int start, input int stop, input logic ps, input logic gap, input logic er0);
    for (int i = start; i < stop; i++) begin
      logic [7:0] g;
      g = 8'(i);
      px(1, {g, g, g}, i == 0, 1, i == W*H-1, ps, (i == start) && er0, g);
      if (gap) idle(1);
    end
  endtask
  task automatic mark;
    bv = nv; bl = nl; be = ne;
  endtask
  task automatic counts(input string tag, input int v, input int l, input int e);
    idle(4);
    chk({tag, "_nvalid"}, nv - bv, v);
    chk({tag, "_nlast"}, nl - bl, l);
    chk({tag, "_nerr"}, ne - be, e);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_data", y_data, 0);
    chk("rst_y_last", y_last, 0);
    chk("rst_pass", pass, 0);
    chk("rst_frame_err", frame_err, 0);
    rst_n = 1;
    idle(2);
    mark;
    repeat (10) px(1, {8'd200, 8'd100, 8'd50}, 0, 0, 0, 0, 0, '0);
    counts("drop", 0, 0, 0);
    mark;
    px(1, 24'hFF0000, 1, 1, 0, 0, 0, RED_Y);
    px(1, 24'hFFFFFF, 0, 1, 0, 0, 0, 8'd255);
    gray_frame(2, W*H, 0, 0, 0);
    counts("frame1", W*H, 1, 0);
    mark;
    gray_frame(0, W*H, 1, 0, 0);
    counts("frame2", W*H, 1, 0);
    mark;
    gray_frame(0, W*H, 0, 1, 0);
    counts("gapped", W*H, 1, 0);
    mark;
    gray_frame(0, 50, 1, 0, 0);
    gray_frame(0, W*H, 0, 0, 1);
    counts("early_sof", 50 + W*H, 1, 1);
    gray_frame(0, 70, 1, 0, 0);
    in_valid = 0; e_acc = 0; e_last = 0; e_pass = 0; e_err = 0;
    #2 rst_n = 0;
    #1;
    chk("async_y_valid", y_valid, 0);
    chk("async_y_data", y_data, 0);
    chk("async_y_last", y_last, 0);
    chk("async_pass", pass, 0);
    chk("async_frame_err", frame_err, 0);
    @(posedge clk); #1;
    idle(2);
    rst_n = 1;
    idle(1);
    mark;
    gray_frame(0, W*H, 0, 0, 0);
    counts("after_rst", W*H, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
